transform_inverse_core: RTL

Sequential 4x4 inverse-transform engine that sits directly downstream of the inverse-zigzag stage. It drives col_counter into that stage and takes one dequantised coefficient column per cycle. It runs a vertical 1D pass into a transpose buffer, then a horizontal 1D pass, and emits one row of results per cycle to the residual/reconstruction stage. It supports the 4x4 IDCT (luma 4x4, luma AC, chroma AC), the 4x4 Hadamard (luma DC) and the 2x2 Hadamard (chroma DC).

---
 rtl/transform_inverse_core_pkg.sv | 24 ++
 rtl/transform_inverse_core_butterfly.sv | 39 +++
 rtl/transform_inverse_core.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/transform_inverse_core_pkg.sv
// Shared definitions for the 4x4 inverse-transform engine.
//   - block-type codes presented on block_type
//   - FSM state encoding
//   - IDCT output rounding constant and shift
package transform_inverse_core_pkg;

  localparam logic [2:0] BLK_LUMA_DC   = 3'd0;
  localparam logic [2:0] BLK_LUMA_4X4  = 3'd1;
  localparam logic [2:0] BLK_LUMA_AC   = 3'd2;
  localparam logic [2:0] BLK_CHROMA_DC = 3'd5;
  localparam logic [2:0] BLK_CHROMA_AC = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COL  = 2'd1,
    ST_ROW  = 2'd2,
    ST_CDC  = 2'd3
  } state_t;

  // IDCT results are rounded as (x + RND_ADD) >>> RND_SHIFT.
  localparam int RND_ADD   = 32;
  localparam int RND_SHIFT = 6;

endpackage

// File: rtl/transform_inverse_core_butterfly.sv
// transform_butterfly_1d: combinational 4-point 1D transform.
//   a0..a3    : signed inputs at IW
//   hadamard  : 1 = 4-point Hadamard, 0 = 4x4 integer IDCT butterfly
//   o0..o3    : signed outputs at IW (two's complement, wraps on overflow)
module transform_butterfly_1d #(
  parameter int IW = 18
) (
  input  logic signed [IW-1:0] a0,
  input  logic signed [IW-1:0] a1,
  input  logic signed [IW-1:0] a2,
  input  logic signed [IW-1:0] a3,
  input  logic                 hadamard,
  output logic signed [IW-1:0] o0,
  output logic signed [IW-1:0] o1,
  output logic signed [IW-1:0] o2,
  output logic signed [IW-1:0] o3
);

  logic signed [IW-1:0] e0, e1, e2, e3;

  always_comb begin
    e0 = a0 + a2;
    e1 = a0 - a2;
    e2 = (a1 >>> 1) - a3;
    e3 = a1 + (a3 >>> 1);
    if (hadamard) begin
      o0 = a0 + a1 + a2 + a3;
      o1 = a0 + a1 - a2 - a3;
      o2 = a0 - a1 - a2 + a3;
      o3 = a0 - a1 + a2 - a3;
    end else begin
      o0 = e0 + e3;
      o1 = e1 + e2;
      o2 = e1 - e2;
      o3 = e0 - e3;
    end
  end

endmodule

// File: rtl/transform_inverse_core.sv
// transform_inverse_core: sequential 4x4 inverse transform (IDCT, 4x4 and
// 2x2 Hadamard). Column pass into a transpose buffer, then row pass.
//   start/block_type     : block request, sampled only in IDLE
//   col_counter          : column index fed to the inverse-zigzag stage
//   col_in_0..3          : signed column (row k of column col_counter)
//   coeff_consumed       : pulse in the last input cycle
//   busy                 : block in flight, including the last output cycle
//   res_valid/row_counter/res_out_0..3 : one result row per cycle
//
// Handshake: there is no ready. A row is transferred in every cycle where
// res_valid=1; the consumer must accept it. start is a request without
// acknowledge: it is taken only when the FSM is IDLE and no row is being
// presented, otherwise it is dropped.
module transform_inverse_core
  import transform_inverse_core_pkg::*;
#(
  parameter int DW = 16,
  parameter int IW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           block_type,
  output logic [1:0]           col_counter,
  input  logic signed [DW-1:0] col_in_0,
  input  logic signed [DW-1:0] col_in_1,
  input  logic signed [DW-1:0] col_in_2,
  input  logic signed [DW-1:0] col_in_3,
  output logic                 coeff_consumed,
  output logic                 busy,
  output logic                 res_valid,
  output logic [1:0]           row_counter,
  output logic signed [DW-1:0] res_out_0,
  output logic signed [DW-1:0] res_out_1,
  output logic signed [DW-1:0] res_out_2,
  output logic signed [DW-1:0] res_out_3
);

  localparam logic signed [IW-1:0] RND_CONST = IW'(RND_ADD);

  state_t               state_q, state_d;
  logic [2:0]           type_q;
  logic [1:0]           col_cnt_q, row_idx_q;
  logic signed [IW-1:0] tbuf_q [4][4];

  logic                 accept, is_cdc, col_had, row_had;
  logic signed [IW-1:0] ca0, ca1, ca2, ca3, co0, co1, co2, co3;
  logic signed [IW-1:0] ro0, ro1, ro2, ro3;

  function automatic logic signed [IW-1:0] sext(input logic signed [DW-1:0] v);
    return {{(IW-DW){v[DW-1]}}, v};
  endfunction

  // IDCT rows are rounded and scaled down; Hadamard rows pass through.
  function automatic logic [DW-1:0] finish_val(input logic signed [IW-1:0] x,
                                               input logic hadamard);
    logic signed [IW-1:0] rounded;
    rounded = (x + RND_CONST) >>> RND_SHIFT;
    return hadamard ? x[DW-1:0] : rounded[DW-1:0];
  endfunction

  // The final row is registered while the FSM is already IDLE; gating on
  // res_valid keeps start ignored until that row has gone out.
  assign accept  = start && (state_q == ST_IDLE) && !res_valid;
  assign is_cdc  = (state_q == ST_CDC);
  assign col_had = is_cdc || (type_q == BLK_LUMA_DC);
  assign row_had = (type_q == BLK_LUMA_DC);

  // Chroma DC feeds c0,c2,c1,c3 so the Hadamard outputs o0,o1,o3,o2 give
  // f0..f3 in order.
  assign ca0 = sext(col_in_0);
  assign ca1 = is_cdc ? sext(col_in_2) : sext(col_in_1);
  assign ca2 = is_cdc ? sext(col_in_1) : sext(col_in_2);
  assign ca3 = sext(col_in_3);

  transform_butterfly_1d #(.IW(IW)) u_col (
    .a0(ca0), .a1(ca1), .a2(ca2), .a3(ca3), .hadamard(col_had),
    .o0(co0), .o1(co1), .o2(co2), .o3(co3)
  );

  transform_butterfly_1d #(.IW(IW)) u_row (
    .a0(tbuf_q[row_idx_q][0]), .a1(tbuf_q[row_idx_q][1]),
    .a2(tbuf_q[row_idx_q][2]), .a3(tbuf_q[row_idx_q][3]),
    .hadamard(row_had),
    .o0(ro0), .o1(ro1), .o2(ro2), .o3(ro3)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (block_type == BLK_CHROMA_DC) ? ST_CDC : ST_COL;
      ST_COL:  if (col_cnt_q == 2'd3) state_d = ST_ROW;
      ST_ROW:  if (row_idx_q == 2'd3) state_d = ST_IDLE;
      ST_CDC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latched type, counters, transpose buffer, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q      <= 3'd0;
      col_cnt_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      res_valid   <= 1'b0;
      row_counter <= 2'd0;
      res_out_0   <= '0;
      res_out_1   <= '0;
      res_out_2   <= '0;
      res_out_3   <= '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tbuf_q[r][c] <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            type_q    <= block_type;
            col_cnt_q <= 2'd0;
            row_idx_q <= 2'd0;
          end
        end
        ST_COL: begin
          tbuf_q[0][col_cnt_q] <= co0;
          tbuf_q[1][col_cnt_q] <= co1;
          tbuf_q[2][col_cnt_q] <= co2;
          tbuf_q[3][col_cnt_q] <= co3;
          col_cnt_q            <= col_cnt_q + 2'd1;  // wraps to 0 for next block
        end
        ST_ROW: begin
          res_valid   <= 1'b1;
          row_counter <= row_idx_q;
          res_out_0   <= finish_val(ro0, row_had);
          res_out_1   <= finish_val(ro1, row_had);
          res_out_2   <= finish_val(ro2, row_had);
          res_out_3   <= finish_val(ro3, row_had);
          row_idx_q   <= row_idx_q + 2'd1;
        end
        ST_CDC: begin
          res_valid   <= 1'b1;
          row_counter <= 2'd0;
          res_out_0   <= co0[DW-1:0];
          res_out_1   <= co1[DW-1:0];
          res_out_2   <= co3[DW-1:0];
          res_out_3   <= co2[DW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign col_counter    = col_cnt_q;
  assign coeff_consumed = ((state_q == ST_COL) && (col_cnt_q == 2'd3)) || is_cdc;
  assign busy           = (state_q != ST_IDLE) || res_valid;

endmodule
